// File: rtl/capture_ctrl_pkg.sv
// Shared types for the capture controller: state encoding and counter sizing.
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRIME   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FULL    = 3'd4,
    ST_SEND    = 3'd5
  } state_e;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/capture_ctrl_fsm_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the input rises.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q    <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      d_q    <= d_i;
      rise_o <= d_i & ~d_q;
    end
  end

endmodule

// File: rtl/capture_ctrl_fsm.sv
// Capture sequencer: coefficient load, FIR priming, bounded FIFO fill, paced read-out.
module capture_ctrl_fsm
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned N_COEF      = 16,
  parameter int unsigned CAPTURE_LEN = 1024,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter bit          AUTO_REARM  = 1'b0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               load_coef_i,
  input  logic                               send_i,
  input  logic                               coef_valid_i,
  input  logic                               fir_ready_i,
  input  logic                               sample_valid_i,
  input  logic                               fifo_full_i,
  input  logic                               fifo_empty_i,
  input  logic                               tx_ready_i,
  output logic                               en_recepcion_o,
  output logic                               en_fir_o,
  output logic                               wr_o,
  output logic                               rd_o,
  output logic                               led_full_o,
  output logic [cnt_width(N_COEF)-1:0]       coef_count_o,
  output logic [cnt_width(CAPTURE_LEN)-1:0]  sample_count_o,
  output logic [2:0]                         state_o
);

  localparam int unsigned CW = cnt_width(N_COEF);
  localparam int unsigned SW = cnt_width(CAPTURE_LEN);
  localparam logic [CW-1:0] COEF_LAST = CW'(N_COEF);
  localparam logic [SW-1:0] SMP_LAST  = SW'(CAPTURE_LEN);

  if (N_COEF < 1) begin : g_bad_ncoef
    $error("capture_ctrl_fsm: N_COEF must be at least 1");
  end
  if (CAPTURE_LEN < 1 || CAPTURE_LEN > FIFO_DEPTH) begin : g_bad_len
    $error("capture_ctrl_fsm: CAPTURE_LEN must be in 1..FIFO_DEPTH");
  end

  logic load_rise;
  logic send_rise;

  edge_detect u_load_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (load_coef_i),
    .rise_o (load_rise)
  );

  edge_detect u_send_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (send_i),
    .rise_o (send_rise)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] coef_cnt_q, coef_cnt_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic          wr_ok;
  logic          rd_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      coef_cnt_q <= '0;
      samp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      coef_cnt_q <= coef_cnt_d;
      samp_cnt_q <= samp_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    samp_cnt_d = samp_cnt_q;
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;

    // An abort bypasses the per-state logic, so strobes stay low in that cycle.
    if (load_rise && state_q != ST_LOAD) begin
      state_d    = ST_LOAD;
      coef_cnt_d = '0;
      samp_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (coef_cnt_q == COEF_LAST) begin
            state_d = ST_PRIME;
          end else if (coef_valid_i) begin
            coef_cnt_d = coef_cnt_q + 1'b1;
            if (coef_cnt_q == COEF_LAST - 1'b1) state_d = ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (fir_ready_i) begin
            state_d    = ST_CAPTURE;
            samp_cnt_d = '0;
          end
        end
        ST_CAPTURE: begin
          wr_ok = sample_valid_i & ~fifo_full_i;
          if (wr_ok && samp_cnt_q != SMP_LAST) samp_cnt_d = samp_cnt_q + 1'b1;
          if (fifo_full_i || samp_cnt_q == SMP_LAST ||
              (wr_ok && samp_cnt_q == SMP_LAST - 1'b1)) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (send_rise) state_d = ST_SEND;
        end
        ST_SEND: begin
          rd_ok = tx_ready_i & ~fifo_empty_i;
          if (fifo_empty_i) state_d = AUTO_REARM ? ST_PRIME : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    en_recepcion_o = (state_q == ST_LOAD);
    en_fir_o       = (state_q == ST_PRIME) || (state_q == ST_CAPTURE);
    led_full_o     = (state_q == ST_FULL);
  end

  assign wr_o           = wr_ok;
  assign rd_o           = rd_ok;
  assign coef_count_o   = coef_cnt_q;
  assign sample_count_o = samp_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_capture_ctrl_fsm.sv
// Directed bench for capture_ctrl_fsm: two instances differing only in AUTO_REARM.
module tb_capture_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, load, send, cv, fr, sv, ff, fe, txr;

  logic       er0, ef0, wr0, rd0, lf0;
  logic [2:0] cc0, st0;
  logic [3:0] sc0;
  logic       er1, ef1, wr1, rd1, lf1;
  logic [2:0] cc1, st1;
  logic [3:0] sc1;

  int checks = 0;
  int errors = 0;
  int nwr0, nwr1, nrd0, nrd1;

  capture_ctrl_fsm #(.N_COEF(4), .CAPTURE_LEN(8), .FIFO_DEPTH(8), .AUTO_REARM(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .load_coef_i(load), .send_i(send),
    .coef_valid_i(cv), .fir_ready_i(fr), .sample_valid_i(sv),
    .fifo_full_i(ff), .fifo_empty_i(fe), .tx_ready_i(txr),
    .en_recepcion_o(er0), .en_fir_o(ef0), .wr_o(wr0), .rd_o(rd0), .led_full_o(lf0),
    .coef_count_o(cc0), .sample_count_o(sc0), .state_o(st0)
  );

  capture_ctrl_fsm #(.N_COEF(4), .CAPTURE_LEN(8), .FIFO_DEPTH(8), .AUTO_REARM(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .load_coef_i(load), .send_i(send),
    .coef_valid_i(cv), .fir_ready_i(fr), .sample_valid_i(sv),
    .fifo_full_i(ff), .fifo_empty_i(fe), .tx_ready_i(txr),
    .en_recepcion_o(er1), .en_fir_o(ef1), .wr_o(wr1), .rd_o(rd1), .led_full_o(lf1),
    .coef_count_o(cc1), .sample_count_o(sc1), .state_o(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                      input logic [31:0] exp);
    chk({tag, "/rearm0"}, o0, exp);
    chk({tag, "/rearm1"}, o1, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk2({tag, "_state"}, 32'(st0), 32'(st1), 0);
    chk2({tag, "_en_rx"}, 32'(er0), 32'(er1), 0);
    chk2({tag, "_en_fir"}, 32'(ef0), 32'(ef1), 0);
    chk2({tag, "_wr"}, 32'(wr0), 32'(wr1), 0);
    chk2({tag, "_rd"}, 32'(rd0), 32'(rd1), 0);
    chk2({tag, "_led"}, 32'(lf0), 32'(lf1), 0);
    chk2({tag, "_coef_cnt"}, 32'(cc0), 32'(cc1), 0);
    chk2({tag, "_samp_cnt"}, 32'(sc0), 32'(sc1), 0);
  endtask

  // Assumes both instances are in LOAD; delivers four spaced coefficient strobes.
  task automatic load_coefs();
    for (int k = 0; k < 4; k++) begin
      cv = 1'b1; cyc();
      cv = 1'b0; cyc();
      if (k == 2) begin
        chk2("coef_cnt_3", 32'(cc0), 32'(cc1), 3);
        chk2("still_load", 32'(st0), 32'(st1), 1);
        chk2("en_rx_load", 32'(er0), 32'(er1), 1);
      end
    end
    chk2("coef_cnt_4", 32'(cc0), 32'(cc1), 4);
    chk2("prime_state", 32'(st0), 32'(st1), 2);
    chk2("prime_en_fir", 32'(ef0), 32'(ef1), 1);
    chk2("prime_en_rx", 32'(er0), 32'(er1), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; send = 1'b0; cv = 1'b0; fr = 1'b0;
    sv = 1'b0; ff = 1'b0; fe = 1'b1; txr = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Load edge: two cycles to LOAD; button stays held through PRIME.
    load = 1'b1; cyc();
    chk2("edge_latency", 32'(st0), 32'(st1), 0);
    cyc();
    chk2("enter_load", 32'(st0), 32'(st1), 1);
    chk2("enter_load_en_rx", 32'(er0), 32'(er1), 1);
    load_coefs();

    // Full capture of 8 samples with continuous sample_valid.
    fr = 1'b1; sv = 1'b1; cyc();
    chk2("capture_state", 32'(st0), 32'(st1), 3);
    nwr0 = 0; nwr1 = 0;
    for (int i = 0; i < 12; i++) begin
      nwr0 += int'(wr0); nwr1 += int'(wr1);
      cyc();
    end
    chk2("write_pulses", 32'(nwr0), 32'(nwr1), 8);
    chk2("full_state", 32'(st0), 32'(st1), 4);
    chk2("full_samp_cnt", 32'(sc0), 32'(sc1), 8);
    chk2("full_led", 32'(lf0), 32'(lf1), 1);
    chk2("full_en_fir", 32'(ef0), 32'(ef1), 0);
    fr = 1'b0; sv = 1'b0; load = 1'b0;

    // Paced drain: tx_ready toggles, FIFO empties after 8 reads.
    fe = 1'b0; send = 1'b1; cyc(); cyc();
    chk2("send_state", 32'(st0), 32'(st1), 5);
    nrd0 = 0; nrd1 = 0;
    for (int i = 0; i < 40 && nrd0 < 8; i++) begin
      txr = (i % 2 == 0);
      #1;
      chk2("rd_pace", 32'(rd0), 32'(rd1), 32'(txr));
      nrd0 += int'(rd0); nrd1 += int'(rd1);
      cyc();
    end
    chk2("read_pulses", 32'(nrd0), 32'(nrd1), 8);
    fe = 1'b1; txr = 1'b1; #1;
    chk2("rd_empty", 32'(rd0), 32'(rd1), 0);
    cyc();
    chk("drain_exit/rearm0", 32'(st0), 0);
    chk("drain_exit/rearm1", 32'(st1), 2);
    chk2("drain_exit_rd", 32'(rd0), 32'(rd1), 0);
    send = 1'b0; txr = 1'b0;

    // Re-load: IDLE->LOAD on one instance, abort from PRIME on the other.
    load = 1'b1; cyc(); cyc();
    chk2("reload_state", 32'(st0), 32'(st1), 1);
    chk2("reload_coef_cnt", 32'(cc0), 32'(cc1), 0);
    load_coefs();
    load = 1'b0;

    // FIFO full after 5 writes; send held across FULL entry.
    fr = 1'b1; sv = 1'b1; cyc();
    send = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk2("wr_before_full", 32'(wr0), 32'(wr1), 1);
      cyc();
    end
    chk2("samp_cnt_5", 32'(sc0), 32'(sc1), 5);
    ff = 1'b1; #1;
    chk2("wr_full_blocked", 32'(wr0), 32'(wr1), 0);
    cyc();
    chk2("full_by_fifo", 32'(st0), 32'(st1), 4);
    chk2("full_by_fifo_cnt", 32'(sc0), 32'(sc1), 5);
    ff = 1'b0; sv = 1'b0; fr = 1'b0; fe = 1'b0; txr = 1'b1;
    cyc(); cyc(); cyc();
    chk2("send_held_state", 32'(st0), 32'(st1), 4);
    chk2("send_held_rd", 32'(rd0), 32'(rd1), 0);
    send = 1'b0; cyc();
    send = 1'b1; cyc(); cyc();
    chk2("fresh_send", 32'(st0), 32'(st1), 5);
    chk2("fresh_send_rd", 32'(rd0), 32'(rd1), 1);

    // Abort mid-SEND.
    load = 1'b1; cyc();
    chk2("rd_abort", 32'(rd0), 32'(rd1), 0);
    cyc();
    chk2("abort_send_state", 32'(st0), 32'(st1), 1);
    chk2("abort_send_rd", 32'(rd0), 32'(rd1), 0);
    chk2("abort_send_coef", 32'(cc0), 32'(cc1), 0);
    chk2("abort_send_samp", 32'(sc0), 32'(sc1), 0);
    send = 1'b0; txr = 1'b0; fe = 1'b1;
    load_coefs();
    load = 1'b0;

    // Abort mid-CAPTURE.
    fr = 1'b1; sv = 1'b1; cyc(); cyc(); cyc();
    chk2("samp_cnt_2", 32'(sc0), 32'(sc1), 2);
    load = 1'b1; cyc();
    chk2("wr_abort", 32'(wr0), 32'(wr1), 0);
    cyc();
    chk2("abort_cap_state", 32'(st0), 32'(st1), 1);
    chk2("abort_cap_samp", 32'(sc0), 32'(sc1), 0);
    chk2("abort_cap_coef", 32'(cc0), 32'(cc1), 0);
    chk2("abort_cap_wr", 32'(wr0), 32'(wr1), 0);
    chk2("abort_cap_en_fir", 32'(ef0), 32'(ef1), 0);
    load = 1'b0; fr = 1'b0; sv = 1'b0;

    // Asynchronous reset mid-LOAD.
    cv = 1'b1; cyc(); cv = 1'b0; cyc();
    cv = 1'b1; cyc(); cv = 1'b0; cyc();
    chk2("mid_load_coef", 32'(cc0), 32'(cc1), 2);
    chk2("mid_load_en_rx", 32'(er0), 32'(er1), 1);
    rst_n = 1'b0; #2;
    chk_all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk2("restart_idle", 32'(st0), 32'(st1), 0);
    load = 1'b1; cyc(); cyc();
    chk2("restart_load", 32'(st0), 32'(st1), 1);
    load = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
